// File: rtl/fpu.sv
// fpu: binary32 adder/subtractor, single registered output stage.
// Ports: i_clk, i_rst_n (async, active-low), i_valid, i_32_a, i_32_b,
//   i_add_sub (0: a+b, 1: a-b) -> o_valid, o_32_s, o_ov_flag, o_un_flag.
// Define FPU_DENORM_EN for gradual underflow; otherwise flush-to-zero.
module fpu (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_32_a,
    input  logic [31:0] i_32_b,
    input  logic        i_add_sub,
    output logic        o_valid,
    output logic [31:0] o_32_s,
    output logic        o_ov_flag,
    output logic        o_un_flag
);

    // Leading zeros of a 27-bit value; 27 when the value is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    logic        sa;
    logic        sb;
    logic [7:0]  ea_f;
    logic [7:0]  eb_f;
    logic [22:0] fa;
    logic [22:0] fb;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic [22:0] fa_u;
    logic [22:0] fb_u;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        a_big;
    logic        sx;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [23:0] mx;
    logic [23:0] my;
    logic [7:0]  d;
    logic [49:0] ysh;
    logic [26:0] x_al;
    logic [26:0] y_al;
    logic        eff_sub;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [7:0]  lim;
    logic [7:0]  sh;
    logic [26:0] nrm;
    logic [9:0]  ne;
    logic [23:0] mant;
    logic        up;
    logic [24:0] mr;
    logic [9:0]  fe;
    logic [22:0] frac;
    logic [31:0] res;

    assign sa   = i_32_a[31];
    assign sb   = i_32_b[31] ^ i_add_sub;
    assign ea_f = i_32_a[30:23];
    assign eb_f = i_32_b[30:23];
    assign fa   = i_32_a[22:0];
    assign fb   = i_32_b[22:0];

    assign a_nan = (&ea_f) & (|fa);
    assign b_nan = (&eb_f) & (|fb);
    assign a_inf = (&ea_f) & ~(|fa);
    assign b_inf = (&eb_f) & ~(|fb);

`ifdef FPU_DENORM_EN
    assign fa_u = fa;
    assign fb_u = fb;
`else
    // Subnormal operands collapse to signed zero.
    assign fa_u = (ea_f == 8'd0) ? 23'd0 : fa;
    assign fb_u = (eb_f == 8'd0) ? 23'd0 : fb;
`endif

    // Subnormals use effective exponent 1 with hidden bit 0.
    assign ma = {|ea_f, fa_u};
    assign mb = {|eb_f, fb_u};
    assign ea = (ea_f == 8'd0) ? 8'd1 : ea_f;
    assign eb = (eb_f == 8'd0) ? 8'd1 : eb_f;

    assign a_big = {ea, ma} >= {eb, mb};
    assign sx    = a_big ? sa : sb;
    assign ex    = a_big ? ea : eb;
    assign ey    = a_big ? eb : ea;
    assign mx    = a_big ? ma : mb;
    assign my    = a_big ? mb : ma;
    assign d     = ex - ey;

    // Align: 24-bit significand, guard, round, sticky.
    assign ysh  = {my, 26'd0} >> d;
    assign y_al = (d >= 8'd26) ? {26'd0, |my}
                               : {ysh[49:24], |ysh[23:0]};
    assign x_al = {mx, 3'b000};

    assign eff_sub = sa ^ sb;
    assign sum = eff_sub ? ({1'b0, x_al} - {1'b0, y_al})
                         : ({1'b0, x_al} + {1'b0, y_al});

    // Left shift is capped so the exponent never drops below 1.
    assign lz  = lzc27(sum[26:0]);
    assign lim = ex - 8'd1;
    assign sh  = ({3'b000, lz} > lim) ? lim : {3'b000, lz};

    always_comb begin
        nrm = '0;
        ne  = '0;
        if (sum[27]) begin
            nrm = {sum[27:2], |sum[1:0]};
            ne  = {2'b00, ex} + 10'd1;
        end else begin
            nrm = sum[26:0] << sh;
            ne  = {2'b00, ex} - {2'b00, sh};
        end
    end

    // Round to nearest, ties to even.
    assign mant = nrm[26:3];
    assign up   = nrm[2] & ((|nrm[1:0]) | nrm[3]);
    assign mr   = {1'b0, mant} + 25'(up);

    always_comb begin
        fe   = '0;
        frac = '0;
        if (mr[24]) begin
            fe   = ne + 10'd1;
            frac = mr[23:1];
        end else begin
            // A subnormal that rounds up into bit 23 becomes exp 1.
            fe   = mr[23] ? ne : 10'd0;
            frac = mr[22:0];
        end
    end

    always_comb begin
        res = '0;
        if (a_nan) begin
            res = {i_32_a[31], 8'hFF, 1'b1, fa[21:0]};
        end else if (b_nan) begin
            res = {i_32_b[31], 8'hFF, 1'b1, fb[21:0]};
        end else if (a_inf & b_inf & eff_sub) begin
            res = 32'hFFC0_0000;
        end else if (a_inf) begin
            res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            res = {sb, 8'hFF, 23'd0};
        end else if (sum == 28'd0) begin
            // Exact zero is -0 only when both addends are negative.
            res = {sa & sb, 31'd0};
        end else if (fe >= 10'd255) begin
            res = {sx, 8'hFF, 23'd0};
`ifndef FPU_DENORM_EN
        end else if (fe == 10'd0) begin
            res = {sx, 31'd0};
`endif
        end else begin
            res = {sx, fe[7:0], frac};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            o_32_s    <= 32'd0;
            o_ov_flag <= 1'b0;
            o_un_flag <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_32_s    <= res;
                o_ov_flag <= &res[30:23];
                o_un_flag <= ~(|res[30:23]);
            end
        end
    end

endmodule

// File: tb/tb_fpu.sv
// tb_fpu: directed table plus random vectors for the fpu adder,
// checked against a real-arithmetic reference with explicit rounding.
module tb_fpu;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_32_a = '0;
    logic [31:0] i_32_b = '0;
    logic        i_add_sub = 1'b0;
    logic        o_valid;
    logic [31:0] o_32_s;
    logic        o_ov_flag;
    logic        o_un_flag;

    fpu dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_32_a   (i_32_a),
        .i_32_b   (i_32_b),
        .i_add_sub(i_add_sub),
        .o_valid  (o_valid),
        .o_32_s   (o_32_s),
        .o_ov_flag(o_ov_flag),
        .o_un_flag(o_un_flag)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] s;
        logic        ov;
        logic        un;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic        exp_v = 1'b0;
    logic [31:0] exp_s = '0;
    logic        exp_ov = 1'b0;
    logic        exp_un = 1'b0;
    string       pend_nm = "reset";
    vec_t        tv[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic check_state(input string nm, input logic v,
                               input logic [31:0] s, input logic ov,
                               input logic un);
        chk({nm, ".valid"}, {31'd0, o_valid}, {31'd0, v});
        chk({nm, ".s"}, o_32_s, s);
        chk({nm, ".ov"}, {31'd0, o_ov_flag}, {31'd0, ov});
        chk({nm, ".un"}, {31'd0, o_un_flag}, {31'd0, un});
    endtask

    // Checks the result of the previous cycle, then drives a new one.
    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic op,
                         input logic [31:0] e_s, input logic e_ov,
                         input logic e_un, input string nm);
        @(negedge i_clk);
        check_state(pend_nm, exp_v, exp_s, exp_ov, exp_un);
        i_valid   = v;
        i_32_a    = a;
        i_32_b    = b;
        i_add_sub = op;
        exp_v     = v;
        if (v) begin
            exp_s  = e_s;
            exp_ov = e_ov;
            exp_un = e_un;
        end
        pend_nm = nm;
    endtask

    function automatic real to_real(input logic [31:0] x);
        real m;
        int  e;
        e = int'(x[30:23]);
        m = real'(x[22:0]);
        if (e == 0) m = m * (2.0 ** -149.0);
        else m = (m + 8388608.0) * (2.0 ** real'(e - 150));
        return x[31] ? -m : m;
    endfunction

    // Round a nonzero real (exact or 53-bit) to binary32, nearest-even.
    function automatic logic [31:0] round_f(input real r);
        logic [63:0] rb;
        logic [63:0] sig;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        int          fe;
        int          k;
        logic        s;
        rb  = $realtobits(r);
        s   = rb[63];
        fe  = int'(rb[62:52]) - 1023 + 127;
        sig = {11'd0, 1'b1, rb[51:0]};
        k   = (fe >= 1) ? 29 : 30 - fe;
        if (k >= 54) return {s, 31'd0};
        q    = sig >> k;
        rem  = sig & ((64'd1 << k) - 64'd1);
        half = 64'd1 << (k - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (fe >= 1) begin
            if (q[24]) begin
                q = q >> 1;
                fe++;
            end
            if (fe >= 255) return {s, 8'hFF, 23'd0};
            return {s, 8'(fe), q[22:0]};
        end
        return {s, q[30:0]};
    endfunction

    function automatic logic [31:0] ref_fpu(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic op);
        logic        sb;
        logic        ainf;
        logic        binf;
        logic [31:0] af;
        logic [31:0] bf;
        logic [31:0] res;
        real         r;
        sb = b[31] ^ op;
        if (&a[30:23] && |a[22:0]) return a | 32'h0040_0000;
        if (&b[30:23] && |b[22:0]) return b | 32'h0040_0000;
        ainf = &a[30:23] && (a[22:0] == 23'd0);
        binf = &b[30:23] && (b[22:0] == 23'd0);
        if (ainf && binf && (a[31] != sb)) return 32'hFFC0_0000;
        if (ainf) return a;
        if (binf) return {sb, 31'h7F80_0000};
        af = a;
        bf = {sb, b[30:0]};
`ifndef FPU_DENORM_EN
        if (af[30:23] == 8'd0) af[22:0] = '0;
        if (bf[30:23] == 8'd0) bf[22:0] = '0;
`endif
        r = to_real(af) + to_real(bf);
        if (r == 0.0) return {a[31] & sb, 31'd0};
        res = round_f(r);
`ifndef FPU_DENORM_EN
        if (res[30:23] == 8'd0) res = {res[31], 31'd0};
`endif
        return res;
    endfunction

    function automatic logic [31:0] gen(input logic [31:0] base);
        logic [31:0] x;
        x = $urandom;
        case ($urandom % 5)
            0: x = x;
            1: x[30:23] = base[30:23] + 8'($urandom % 5) - 8'd2;
            2: x[30:23] = 8'($urandom % 3);
            3: begin
                case ($urandom % 8)
                    0: x = 32'h0000_0000;
                    1: x = 32'h8000_0000;
                    2: x = 32'h7F80_0000;
                    3: x = 32'hFF80_0000;
                    4: x = 32'h7FC0_0000;
                    5: x = 32'h7F80_0001;
                    6: x = 32'h7F7F_FFFF;
                    default: x = 32'h0080_0000;
                endcase
            end
            default: x = {x[31], base[30:0]};
        endcase
        return x;
    endfunction

    task automatic rnd_vec(input int n, input logic v);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic        op;
        a  = gen($urandom);
        b  = gen(a);
        op = 1'($urandom % 2);
        e  = ref_fpu(a, b, op);
        drive(v, a, b, op, e, &e[30:23], ~(|e[30:23]),
              $sformatf("rnd%0d a=%h b=%h op=%0d", n, a, b, op));
    endtask

    initial begin
        tv.push_back('{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0});
        tv.push_back('{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1});
        tv.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        tv.push_back('{32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1});
        tv.push_back('{32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1});
        tv.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0});
        tv.push_back('{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'hFFC0_0000, 1'b1, 1'b0});
        tv.push_back('{32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0001, 1'b1, 1'b0});
        tv.push_back('{32'h3F80_0000, 32'hFF80_0005, 1'b1, 32'hFFC0_0005, 1'b1, 1'b0});
        tv.push_back('{32'h7F80_0001, 32'h7FC0_0002, 1'b0, 32'h7FC0_0001, 1'b1, 1'b0});
        tv.push_back('{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 1'b1, 1'b0});
        tv.push_back('{32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b1, 1'b0});
        tv.push_back('{32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0});
        tv.push_back('{32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0, 1'b0});
        tv.push_back('{32'h4B7F_FFFF, 32'h3F00_0000, 1'b0, 32'h4B80_0000, 1'b0, 1'b0});
`ifdef FPU_DENORM_EN
        tv.push_back('{32'h0080_0000, 32'h0040_0000, 1'b1, 32'h0040_0000, 1'b0, 1'b1});
        tv.push_back('{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b1});
        tv.push_back('{32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b1});
        tv.push_back('{32'h8040_0000, 32'h0000_0000, 1'b0, 32'h8040_0000, 1'b0, 1'b1});
`else
        tv.push_back('{32'h0080_0000, 32'h0040_0000, 1'b1, 32'h0080_0000, 1'b0, 1'b0});
        tv.push_back('{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1});
        tv.push_back('{32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1});
        tv.push_back('{32'h8040_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1});
`endif

        repeat (2) @(negedge i_clk);
        check_state("reset", 1'b0, 32'd0, 1'b0, 1'b0);
        i_rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(1'b1, tv[i].a, tv[i].b, tv[i].op, tv[i].s, tv[i].ov,
                  tv[i].un, $sformatf("vec%0d", i));
        end

        // Idle cycle: o_valid drops, result and flags hold.
        drive(1'b0, 32'h4040_0000, 32'h4040_0000, 1'b0, 32'd0, 1'b0,
              1'b0, "hold");
        drive(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000,
              1'b0, 1'b0, "after_hold");

        // Asynchronous reset in the middle of a back-to-back stream.
        for (int i = 0; i < 3; i++) rnd_vec(i, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_state("async_rst", 1'b0, 32'd0, 1'b0, 1'b0);
        exp_v   = 1'b0;
        exp_s   = '0;
        exp_ov  = 1'b0;
        exp_un  = 1'b0;
        pend_nm = "post_rst";
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_valid = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            rnd_vec(n, (n < 100) || (($urandom % 8) != 0));
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "tail");
        @(negedge i_clk);
        check_state(pend_nm, exp_v, exp_s, exp_ov, exp_un);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
